inst_sram_bridge: RTL and testbench
===================================

INST_SRAM_BRIDGE -- requirements
Module: inst_sram_bridge

Interface
REQ-001 Parameter BUF_EN, default 1, SHALL enable the one-entry read buffer when 1; when 0 every read SHALL miss.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 inst_sram_en  input  1  fetch-side request strobe.
REQ-005 inst_sram_wen  input  4  byte write enables; 4'b0 means read.
REQ-006 inst_sram_addr  input  32  virtual byte address.
REQ-007 inst_sram_wdata  input  32  write data.
REQ-008 inst_sram_rdata  output  32  read data, registered.
REQ-009 stallreq  output  1  pipeline stall request, combinational.
REQ-010 mem_req  output  1  backing-memory request, registered.
REQ-011 mem_we  output  4  byte enables to backing memory, held with mem_req.
REQ-012 mem_addr  output  32  physical address, held with mem_req.
REQ-013 mem_wdata  output  32  write data, held with mem_req.
REQ-014 mem_gnt  input  1  backing memory accepts the request this cycle.
REQ-015 mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-016 mem_rdata  input  32  backing read data.

Function
REQ-017 Address translation: addr[31:29] of 3'b100 or 3'b101 (kseg0/kseg1) SHALL map to {3'b000, addr[28:0]}; all other addresses SHALL pass unchanged; 32'hbfc0_0000 SHALL map to 32'h1fc0_0000.
REQ-018 Read protocol: when stallreq is low during the cycle a read is presented, inst_sram_rdata SHALL hold that read's data in the following cycle and SHALL keep it until the next read completes.
REQ-019 States: IDLE, REQ, WAIT; reset state IDLE.
REQ-020 Hit: IDLE, en=1, wen=0, BUF_EN=1, buffer valid, buffer tag equals physical address -> stallreq=0, rdata <= buffer data, stay IDLE; zero backing-memory traffic.
REQ-021 Miss or write in IDLE with en=1: latch physical addr, wen, wdata into mem_addr/mem_we/mem_wdata, set mem_req=1, go to REQ; stallreq=1 that same cycle.
REQ-022 REQ: mem_req held 1 with stable payload until mem_gnt=1; on gnt mem_req <= 0; read -> WAIT; write -> IDLE.
REQ-023 stallreq SHALL be 1 in REQ except in the gnt cycle of a write, where it SHALL be 0.
REQ-024 WAIT: stallreq=1 while mem_rvalid=0; in the mem_rvalid=1 cycle stallreq=0, rdata <= mem_rdata, buffer <= {valid, mem_addr, mem_rdata} (when BUF_EN=1), go to IDLE.
REQ-025 Total read-miss stall = 1 + gnt wait + rvalid wait cycles; minimum 2 cycles stalled (gnt and rvalid both in the first cycles offered).
REQ-026 inst_sram_en and payload SHALL be ignored outside IDLE; the latched request is the only one serviced.
REQ-027 A write whose physical address equals a valid buffer tag SHALL clear the buffer valid bit at the gnt edge; a write does not change inst_sram_rdata.
REQ-028 mem_rvalid outside WAIT and mem_gnt outside REQ SHALL be ignored.
REQ-029 en=0 in IDLE: stallreq=0, no state change, rdata held.

Reset
REQ-030 On rst=1 at a clock edge: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, inst_sram_rdata 0, buffer invalid.
REQ-031 Reset from REQ or WAIT SHALL abandon the transaction; a subsequent stray mem_rvalid SHALL not update rdata or the buffer.
REQ-032 stallreq SHALL be 0 in the cycle after reset when en=0.

Verification
REQ-033 Read miss: en=1, wen=0, addr 32'hbfc0_0000, gnt same cycle mem_req rises, rvalid next cycle with 32'h3c08_0001 -> mem_addr 32'h1fc0_0000, stallreq high 2 cycles, rdata 32'h3c08_0001 the cycle after the rvalid cycle.
REQ-034 Buffer hit: repeat read of 32'hbfc0_0000 immediately -> stallreq 0, mem_req stays 0, rdata 32'h3c08_0001 next cycle; with BUF_EN=0 the same read misses.
REQ-035 Back-pressure: gnt delayed 3 cycles, rvalid delayed 2 cycles after gnt -> mem_req/mem_addr stable for all 4 REQ cycles, stallreq high for 6 cycles total, en toggling during stall ignored.
REQ-036 Write invalidation: write 32'hdead_beef, wen 4'hf, to 32'h9fc0_0000 after buffering 32'hbfc0_0000 -> mem_we 4'hf, stallreq drops in gnt cycle, next read of 32'hbfc0_0000 misses.
REQ-037 Reset mid-WAIT: rst during WAIT, then mem_rvalid with 32'h1234_5678 -> state IDLE, rdata 0, mem_req 0, buffer invalid.
REQ-038 Pass-through: read 32'h0000_1000 -> mem_addr 32'h0000_1000 unchanged.

Source files
------------

// File: rtl/inst_sram_bridge.sv
// Instruction-fetch bridge between the pipeline's SRAM-style port and a request/grant backing memory.
// It translates kseg0/kseg1 addresses and keeps a one-entry read buffer so that repeated fetches do not go to memory.
module inst_sram_bridge #(
  parameter int BUF_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        stallreq,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_reg;
  logic        buf_valid_reg;
  logic [31:0] buf_tag_reg;
  logic [31:0] buf_data_reg;

  logic [31:0] paddr;
  logic        is_read;
  logic        hit;

  // kseg0 and kseg1 both alias the low 512 MB of physical memory.
  always_comb begin
    paddr = inst_sram_addr;
    if (inst_sram_addr[31:30] == 2'b10)
      paddr = {3'b000, inst_sram_addr[28:0]};
  end

  assign is_read = (inst_sram_wen == 4'b0000);
  assign hit     = (BUF_EN != 0) && buf_valid_reg && (buf_tag_reg == paddr);

  always_comb begin
    stallreq = 1'b0;
    case (state_reg)
      IDLE:    stallreq = inst_sram_en && !(is_read && hit);
      // A write needs no response, so the pipeline is released in its grant cycle.
      REQ:     stallreq = !(mem_gnt && (mem_we != 4'b0000));
      WAIT:    stallreq = !mem_rvalid;
      default: stallreq = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      mem_req         <= 1'b0;
      mem_we          <= 4'b0000;
      mem_addr        <= 32'h0;
      mem_wdata       <= 32'h0;
      inst_sram_rdata <= 32'h0;
      buf_valid_reg   <= 1'b0;
      buf_tag_reg     <= 32'h0;
      buf_data_reg    <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (inst_sram_en) begin
            if (is_read && hit) begin
              inst_sram_rdata <= buf_data_reg;
            end else begin
              mem_addr  <= paddr;
              mem_we    <= inst_sram_wen;
              mem_wdata <= inst_sram_wdata;
              mem_req   <= 1'b1;
              state_reg <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we == 4'b0000) begin
              state_reg <= WAIT;
            end else begin
              state_reg <= IDLE;
              // Self-modifying code: drop a buffered copy of the overwritten word.
              if (buf_valid_reg && (buf_tag_reg == mem_addr))
                buf_valid_reg <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            inst_sram_rdata <= mem_rdata;
            state_reg       <= IDLE;
            if (BUF_EN != 0) begin
              buf_valid_reg <= 1'b1;
              buf_tag_reg   <= mem_addr;
              buf_data_reg  <= mem_rdata;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram_bridge.sv
// Directed bench for inst_sram_bridge: miss/hit timing, back-pressure, write invalidation and reset abort.
// A second instance with the buffer disabled shares the stimulus to show that a repeat read still misses.
module tb_inst_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata_in;

  logic [31:0] rdata;
  logic        stall;
  logic        req;
  logic [3:0]  we;
  logic [31:0] maddr;
  logic [31:0] mwdata;

  logic [31:0] n_rdata;
  logic        n_stall;
  logic        n_req;
  logic [3:0]  n_we;
  logic [31:0] n_maddr;
  logic [31:0] n_mwdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inst_sram_bridge #(.BUF_EN(1)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(en), .inst_sram_wen(wen), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .inst_sram_rdata(rdata), .stallreq(stall),
    .mem_req(req), .mem_we(we), .mem_addr(maddr), .mem_wdata(mwdata),
    .mem_gnt(gnt), .mem_rvalid(rvalid), .mem_rdata(rdata_in)
  );

  inst_sram_bridge #(.BUF_EN(0)) dut_nobuf (
    .clk(clk), .rst(rst),
    .inst_sram_en(en), .inst_sram_wen(wen), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .inst_sram_rdata(n_rdata), .stallreq(n_stall),
    .mem_req(n_req), .mem_we(n_we), .mem_addr(n_maddr), .mem_wdata(n_mwdata),
    .mem_gnt(gnt), .mem_rvalid(rvalid), .mem_rdata(rdata_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full read through memory: gdly grant-less REQ cycles, rvalid rdly cycles after the grant.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] pa,
                         input int gdly, input int rdly, input logic [31:0] d, input int exp_stalls);
    int stalls = 0;
    en = 1'b1; wen = 4'h0; addr = a; #1;
    if (stall) stalls++;
    tick();
    check({tag, " mem_req up"}, {31'b0, req}, 32'h1);
    check({tag, " mem_addr"}, maddr, pa);
    for (int i = 0; i < gdly; i++) begin
      en = ~en; addr = 32'h0000_0ff0; #1;
      if (stall) stalls++;
      tick();
      check({tag, " mem_req held"}, {31'b0, req}, 32'h1);
      check({tag, " mem_addr held"}, maddr, pa);
    end
    gnt = 1'b1; #1;
    if (stall) stalls++;
    tick();
    gnt = 1'b0; en = 1'b1; addr = a;
    check({tag, " mem_req drop"}, {31'b0, req}, 32'h0);
    for (int i = 0; i < rdly - 1; i++) begin
      #1;
      if (stall) stalls++;
      tick();
    end
    rvalid = 1'b1; rdata_in = d; #1;
    check({tag, " stall rvalid cyc"}, {31'b0, stall}, 32'h0);
    tick();
    rvalid = 1'b0; rdata_in = 32'h0;
    check({tag, " stall cycles"}, stalls, exp_stalls);
    check({tag, " rdata"}, rdata, d);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    gnt = 1'b0; rvalid = 1'b0; rdata_in = 32'h0;
    tick(); tick();
    rst = 1'b0; #1;
    check("reset rdata", rdata, 32'h0);
    check("reset mem_req", {31'b0, req}, 32'h0);
    check("reset mem_we", {28'b0, we}, 32'h0);
    check("reset mem_addr", maddr, 32'h0);
    check("reset stall en0", {31'b0, stall}, 32'h0);

    // Read miss on the reset vector, fastest memory.
    do_read("miss", 32'hbfc0_0000, 32'h1fc0_0000, 0, 1, 32'h3c08_0001, 2);

    // Immediate repeat read: buffered instance hits, unbuffered one misses.
    en = 1'b1; wen = 4'h0; addr = 32'hbfc0_0000; #1;
    check("hit stall", {31'b0, stall}, 32'h0);
    check("nobuf stall", {31'b0, n_stall}, 32'h1);
    tick();
    check("hit mem_req", {31'b0, req}, 32'h0);
    check("hit rdata", rdata, 32'h3c08_0001);
    check("nobuf mem_req", {31'b0, n_req}, 32'h1);

    en = 1'b0; #1;
    check("idle en0 stall", {31'b0, stall}, 32'h0);
    tick();
    check("idle en0 rdata held", rdata, 32'h3c08_0001);
    check("idle en0 mem_req", {31'b0, req}, 32'h0);

    // Realign the two instances, then back-pressure on a fresh miss.
    rst = 1'b1; tick(); rst = 1'b0;
    do_read("bp", 32'hbfc0_0000, 32'h1fc0_0000, 3, 2, 32'h3c08_0001, 6);

    // Write to the kseg0 alias of the buffered word.
    en = 1'b1; wen = 4'hf; addr = 32'h9fc0_0000; wdata = 32'hdead_beef; #1;
    check("wr stall idle", {31'b0, stall}, 32'h1);
    tick();
    en = 1'b0; wen = 4'h0;
    check("wr mem_we", {28'b0, we}, 32'hf);
    check("wr mem_addr", maddr, 32'h1fc0_0000);
    check("wr mem_wdata", mwdata, 32'hdead_beef);
    #1;
    check("wr stall no gnt", {31'b0, stall}, 32'h1);
    tick();
    gnt = 1'b1; #1;
    check("wr stall gnt", {31'b0, stall}, 32'h0);
    tick();
    gnt = 1'b0;
    check("wr mem_req drop", {31'b0, req}, 32'h0);
    check("wr rdata unchanged", rdata, 32'h3c08_0001);
    do_read("post-wr", 32'hbfc0_0000, 32'h1fc0_0000, 0, 1, 32'h0000_0042, 2);

    do_read("pass", 32'h0000_1000, 32'h0000_1000, 1, 1, 32'h2402_0007, 3);

    // Reset while waiting for read data; a late rvalid must be dropped.
    en = 1'b1; wen = 4'h0; addr = 32'h0000_2000;
    tick();
    gnt = 1'b1; tick(); gnt = 1'b0;
    en = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    check("abort mem_req", {31'b0, req}, 32'h0);
    check("abort rdata", rdata, 32'h0);
    rvalid = 1'b1; rdata_in = 32'h1234_5678; #1;
    check("abort stall en0", {31'b0, stall}, 32'h0);
    tick();
    rvalid = 1'b0; rdata_in = 32'h0;
    check("stray rvalid rdata", rdata, 32'h0);
    en = 1'b1; addr = 32'h0000_2000; #1;
    check("abort buffer invalid", {31'b0, stall}, 32'h1);
    tick();
    check("abort re-request", {31'b0, req}, 32'h1);
    en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
